pipeline_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) from:
  - cache handshakes (ihit/dhit)
  - load-use detection
  - branch/jump redirect
  - halt
- Works alongside the forwarding unit: forwarding resolves ALU-to-ALU hazards; this block handles what forwarding cannot.
- Keeps a small FSM for memory-wait tracking, a memory-wait timeout watchdog, sticky halt, and stall/flush performance counters.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/sat_counter.sv | 39 +++
 rtl/pipeline_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types and constants.
// Holds the word and register-index types used across the datapath,
// the instruction field positions for rs/rt, and the state encoding
// of the pipeline stall/flush sequencer.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Source register fields inside an R/I-type instruction word
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   CLK   - rising-edge clock
//   nRST  - asynchronous active-low reset, clears the count
//   clr   - synchronous clear; when inc is also high the count restarts at 1
//   inc   - increment request, ignored once the count is all-ones
//   count - current count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Clear wins over increment but still counts the clearing cycle,
  // so a new run of events starts at 1 rather than 0.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d    = '0;
      count_d[0] = inc;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Produces PC and pipeline-latch enables and bubble (flush) controls from
// cache handshakes, load-use hazards, EX/MEM redirects and HALT.
// Ports:
//   CLK, nRST                  - clock and asynchronous active-low reset
//   ihit, dhit                 - icache / dcache completion
//   dREN_out_3, dWEN_out_3     - EX/MEM holds a load / store
//   MemRead_out_2, wsel_out_2  - ID/EX load flag and destination register
//   instr_out_1                - IF/ID instruction word (rs/rt fields)
//   redirect_out_3             - taken branch/jump in EX/MEM
//   halt_out_4                 - HALT in MEM/WB
//   pc_en, *_en                - load enables for PC and latches
//   *_flush                    - latch loads a bubble, overriding its enable
//   halt, mem_timeout          - sticky status flags
//   stall_count, flush_count   - saturating performance counters
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_out_3,
  input  logic             dWEN_out_3,
  input  logic             MemRead_out_2,
  input  regbits_t         wsel_out_2,
  input  word_t            instr_out_1,
  input  logic             redirect_out_3,
  input  logic             halt_out_4,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  pctrl_state_t state_q, state_d;
  logic         halt_q, halt_d;
  logic         mem_timeout_q, mem_timeout_d;

  logic              mem_wait, load_use;
  logic              stall_event, flush_event;
  logic              wait_clr, wait_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  regbits_t          rs, rt;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_out_1[31:26], instr_out_1[15:0]};

  assign rs       = instr_out_1[RS_MSB:RS_LSB];
  assign rt       = instr_out_1[RT_MSB:RT_LSB];
  assign mem_wait = (dREN_out_3 | dWEN_out_3) & ~dhit;
  // $zero as a destination never creates a real dependency
  assign load_use = MemRead_out_2 && (wsel_out_2 != '0) &&
                    ((wsel_out_2 == rs) || (wsel_out_2 == rt));

  // Priority table for the enables/flushes; earlier rows mask later ones,
  // so a memory freeze holds a pending redirect until dhit arrives.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_event = 1'b0;
    flush_event = 1'b0;
    if ((state_q == HALTED) || halt_out_4) begin
      // everything held
    end else if (mem_wait) begin
      stall_event = 1'b1;
    end else if (redirect_out_3) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
      {ifid_flush, idex_flush, exmem_flush}         = '1;
      flush_event = 1'b1;
    end else if (load_use) begin
      {idex_en, exmem_en, memwb_en} = '1;
      idex_flush  = 1'b1;
      stall_event = 1'b1;
    end else if (!ihit) begin
      {ifid_en, idex_en, exmem_en, memwb_en} = '1;
      ifid_flush  = 1'b1;
      stall_event = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
    end
  end

  // Memory-wait tracking FSM; HALTED only leaves through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_out_4)    state_d = HALTED;
        else if (mem_wait) state_d = MWAIT;
      end
      MWAIT: begin
        if (halt_out_4)     state_d = HALTED;
        else if (!mem_wait) state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // The wait counter restarts on every entry into MWAIT and counts the
  // entry edge itself. The timeout flag looks at the counter's next value
  // so it rises on the same edge the count reaches MAX_WAIT.
  always_comb begin
    wait_clr  = (state_q != MWAIT);
    wait_inc  = (state_d == MWAIT) && mem_wait && (wait_cnt != WAIT_MAX);
    wait_next = wait_cnt;
    if (wait_clr) begin
      wait_next    = '0;
      wait_next[0] = wait_inc;
    end else if (wait_inc) begin
      wait_next = wait_cnt + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (wait_next == WAIT_MAX);
    halt_d        = halt_q | (state_d == HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      halt_q        <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign halt        = halt_q;
  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (1'b0),
    .inc   (stall_event),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (1'b0),
    .inc   (flush_event),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl.
// Small counter width and short timeout make saturation and the watchdog
// reachable in a few cycles. Inputs change just after the falling edge;
// combinational controls are checked before the rising edge and registered
// outputs just after it.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] C_RUN    = 8'b11111_000;
  localparam logic [7:0] C_FROZEN = 8'b00000_000;
  localparam logic [7:0] C_REDIR  = 8'b11111_111;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_MISS   = 8'b01111_100;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, dREN_out_3, dWEN_out_3, MemRead_out_2;
  regbits_t         wsel_out_2;
  word_t            instr_out_1;
  logic             redirect_out_3, halt_out_4;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic             halt, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [7:0]       ctrl;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

  pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .dREN_out_3     (dREN_out_3),
    .dWEN_out_3     (dWEN_out_3),
    .MemRead_out_2  (MemRead_out_2),
    .wsel_out_2     (wsel_out_2),
    .instr_out_1    (instr_out_1),
    .redirect_out_3 (redirect_out_3),
    .halt_out_4     (halt_out_4),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .halt           (halt),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  task automatic idle_inputs();
    ihit           = 1'b1;
    dhit           = 1'b0;
    dREN_out_3     = 1'b0;
    dWEN_out_3     = 1'b0;
    MemRead_out_2  = 1'b0;
    wsel_out_2     = '0;
    instr_out_1    = '0;
    redirect_out_3 = 1'b0;
    halt_out_4     = 1'b0;
  endtask

  // Reset through one rising edge, release on the following falling edge
  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // From a falling edge: settle, then move to just after the rising edge
  task automatic to_post_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST           = 1'b0;
    idle_inputs();
    #1;
    total++;
    if (halt !== 1'b0 || mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got halt=%b timeout=%b want 0 0", halt, mem_timeout);
    end
    total++;
    if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_counts: got stall=%0d flush=%0d want 0 0", stall_count, flush_count);
    end
    total++;
    if (dut.state_q !== RUN || ctrl !== C_RUN) begin
      bad++;
      $display("FAIL reset_ctrl: got state=%0d ctrl=%b want 0 %b", dut.state_q, ctrl, C_RUN);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_out_2 = 1'b1;
    wsel_out_2    = 5'd5;
    instr_out_1   = 32'h00A7_0000;  // rs=5, rt=7
    #1;
    total++;
    if (ctrl !== C_LU) begin
      bad++;
      $display("FAIL lu_rs_ctrl: got %b want %b", ctrl, C_LU);
    end
    to_post_edge();
    total++;
    if (stall_count !== 4'd1) begin
      bad++;
      $display("FAIL lu_rs_count: got %0d want 1", stall_count);
    end
    @(negedge CLK);
    wsel_out_2 = 5'd7;
    #1;
    total++;
    if (ctrl !== C_LU) begin
      bad++;
      $display("FAIL lu_rt_ctrl: got %b want %b", ctrl, C_LU);
    end
    to_post_edge();
    @(negedge CLK);
    wsel_out_2  = 5'd0;
    instr_out_1 = 32'h0000_0000;    // rs=rt=0 matches but $zero is exempt
    #1;
    total++;
    if (ctrl !== C_RUN) begin
      bad++;
      $display("FAIL lu_zero_ctrl: got %b want %b", ctrl, C_RUN);
    end
    to_post_edge();
    @(negedge CLK);
    wsel_out_2    = 5'd5;
    instr_out_1   = 32'h00A7_0000;
    MemRead_out_2 = 1'b0;           // not a load: forwarding covers it
    #1;
    total++;
    if (ctrl !== C_RUN) begin
      bad++;
      $display("FAIL lu_noload_ctrl: got %b want %b", ctrl, C_RUN);
    end
    to_post_edge();
    total++;
    if (stall_count !== 4'd2) begin
      bad++;
      $display("FAIL lu_total_count: got %0d want 2", stall_count);
    end
  endtask

  task automatic test_data_wait();
    do_reset();
    dREN_out_3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctrl !== C_FROZEN) begin
        bad++;
        $display("FAIL dwait_ctrl[%0d]: got %b want %b", i, ctrl, C_FROZEN);
      end
      to_post_edge();
      total++;
      if (dut.state_q !== MWAIT) begin
        bad++;
        $display("FAIL dwait_state[%0d]: got %0d want %0d", i, dut.state_q, MWAIT);
      end
      @(negedge CLK);
    end
    dhit = 1'b1;
    #1;
    total++;
    if (ctrl !== C_RUN) begin
      bad++;
      $display("FAIL dwait_release_ctrl: got %b want %b", ctrl, C_RUN);
    end
    to_post_edge();
    total++;
    if (dut.state_q !== RUN || stall_count !== 4'd3) begin
      bad++;
      $display("FAIL dwait_release: got state=%0d stall=%0d want 0 3", dut.state_q, stall_count);
    end
    // Reset in the middle of a wait returns to RUN without a clock edge
    @(negedge CLK);
    dhit = 1'b0;
    to_post_edge();
    nRST = 1'b0;
    #1;
    total++;
    if (dut.state_q !== RUN || stall_count !== 4'd0) begin
      bad++;
      $display("FAIL dwait_reset: got state=%0d stall=%0d want 0 0", dut.state_q, stall_count);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_redirect_miss();
    do_reset();
    redirect_out_3 = 1'b1;
    ihit           = 1'b0;
    #1;
    total++;
    if (ctrl !== C_REDIR) begin
      bad++;
      $display("FAIL redir_miss_ctrl: got %b want %b", ctrl, C_REDIR);
    end
    to_post_edge();
    total++;
    if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
      bad++;
      $display("FAIL redir_miss_counts: got flush=%0d stall=%0d want 1 0", flush_count, stall_count);
    end
    @(negedge CLK);
    ihit          = 1'b1;
    MemRead_out_2 = 1'b1;
    wsel_out_2    = 5'd3;
    instr_out_1   = 32'h0003_0000;  // rt=3 hazard, redirect still wins
    #1;
    total++;
    if (ctrl !== C_REDIR) begin
      bad++;
      $display("FAIL redir_lu_ctrl: got %b want %b", ctrl, C_REDIR);
    end
    to_post_edge();
    @(negedge CLK);
    idle_inputs();
    ihit = 1'b0;
    #1;
    total++;
    if (ctrl !== C_MISS) begin
      bad++;
      $display("FAIL imiss_ctrl: got %b want %b", ctrl, C_MISS);
    end
    to_post_edge();
    total++;
    if (flush_count !== 4'd2 || stall_count !== 4'd1) begin
      bad++;
      $display("FAIL imiss_counts: got flush=%0d stall=%0d want 2 1", flush_count, stall_count);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    redirect_out_3 = 1'b1;
    dREN_out_3     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (ctrl !== C_FROZEN) begin
        bad++;
        $display("FAIL redir_wait_ctrl[%0d]: got %b want %b", i, ctrl, C_FROZEN);
      end
      to_post_edge();
      @(negedge CLK);
    end
    total++;
    if (flush_count !== 4'd0) begin
      bad++;
      $display("FAIL redir_wait_noflush: got %0d want 0", flush_count);
    end
    dhit = 1'b1;
    #1;
    total++;
    if (ctrl !== C_REDIR) begin
      bad++;
      $display("FAIL redir_wait_release_ctrl: got %b want %b", ctrl, C_REDIR);
    end
    to_post_edge();
    total++;
    if (flush_count !== 4'd1 || stall_count !== 4'd2) begin
      bad++;
      $display("FAIL redir_wait_counts: got flush=%0d stall=%0d want 1 2", flush_count, stall_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dWEN_out_3 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      to_post_edge();
      total++;
      if (mem_timeout !== (i == 4)) begin
        bad++;
        $display("FAIL timeout_edge[%0d]: got %b want %b", i, mem_timeout, (i == 4));
      end
      @(negedge CLK);
    end
    dhit = 1'b1;
    to_post_edge();
    @(negedge CLK);
    dWEN_out_3 = 1'b0;
    to_post_edge();
    total++;
    if (mem_timeout !== 1'b1 || stall_count !== 4'd4) begin
      bad++;
      $display("FAIL timeout_sticky: got timeout=%b stall=%0d want 1 4", mem_timeout, stall_count);
    end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_reset: got %b want 0", mem_timeout);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    halt_out_4    = 1'b1;
    MemRead_out_2 = 1'b1;
    wsel_out_2    = 5'd5;
    instr_out_1   = 32'h00A0_0000;
    dREN_out_3    = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FROZEN || halt !== 1'b0) begin
      bad++;
      $display("FAIL halt_first_cycle: got ctrl=%b halt=%b want %b 0", ctrl, halt, C_FROZEN);
    end
    to_post_edge();
    total++;
    if (halt !== 1'b1 || dut.state_q !== HALTED || stall_count !== 4'd0) begin
      bad++;
      $display("FAIL halt_entry: got halt=%b state=%0d stall=%0d want 1 2 0", halt, dut.state_q, stall_count);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    total++;
    if (ctrl !== C_FROZEN) begin
      bad++;
      $display("FAIL halt_hold_ctrl: got %b want %b", ctrl, C_FROZEN);
    end
    to_post_edge();
    total++;
    if (halt !== 1'b1 || stall_count !== 4'd0) begin
      bad++;
      $display("FAIL halt_sticky: got halt=%b stall=%0d want 1 0", halt, stall_count);
    end
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    total++;
    if (halt !== 1'b0 || dut.state_q !== RUN) begin
      bad++;
      $display("FAIL halt_async_reset: got halt=%b state=%0d want 0 0", halt, dut.state_q);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      to_post_edge();
      if (i == 15 || i == 17) begin
        total++;
        if (stall_count !== 4'd15) begin
          bad++;
          $display("FAIL stall_saturate[%0d]: got %0d want 15", i, stall_count);
        end
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_data_wait();
    test_redirect_miss();
    test_redirect_wait();
    test_timeout();
    test_halt();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
